// File: rtl/chip8_pkg.sv
// chip8_pkg: shared FSM states, command encodings and font-area bound for the CHIP-8 store unit
package chip8_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BCD, ST_DUMP, ST_FIN} state_t;
    localparam logic CMD_BCD = 1'b0;
    localparam logic CMD_DUMP = 1'b1;
    localparam logic [11:0] FONT_END_DEF = 12'h050;
endpackage

// File: rtl/chip8_bcd.sv
// chip8_bcd: combinational 8-bit binary to three BCD digits
module chip8_bcd (
    input  logic [7:0] bin,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [7:0] h, t, o;
    assign h = bin / 8'd100;
    assign t = (bin / 8'd10) % 8'd10;
    assign o = bin % 8'd10;
    assign hund = h[3:0];
    assign tens = t[3:0];
    assign ones = o[3:0];
endmodule

// File: rtl/chip8_store_unit.sv
// chip8_store_unit: FX33 BCD store and FX55 register dump; define CHIP8_I_INCREMENT_EN for I write-back after a dump
module chip8_store_unit
    import chip8_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] FONT_END = ADDR_W'(FONT_END_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] i_reg,
    input  logic [3:0]        x_idx,
    input  logic [DATA_W-1:0] bcd_val,
    output logic [3:0]        reg_idx,
    input  logic [DATA_W-1:0] reg_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              i_update,
    output logic [ADDR_W-1:0] i_new
);
    state_t state, state_nxt;
    logic [3:0] step, step_nxt;
    logic cmd_lat;
    logic [ADDR_W-1:0] i_lat;
    logic [3:0] x_lat;
    logic [DATA_W-1:0] val_lat;
    logic [3:0] hund, tens, ones, digit;
    logic wr_act, below;
    logic [ADDR_W-1:0] addr;

    chip8_bcd u_bcd (.bin(val_lat[7:0]), .hund(hund), .tens(tens), .ones(ones));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            step <= 4'd0;
            cmd_lat <= CMD_BCD;
            i_lat <= '0;
            x_lat <= 4'd0;
            val_lat <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            step <= step_nxt;
            if (state == ST_IDLE && start) begin
                cmd_lat <= cmd;
                i_lat <= i_reg;
                x_lat <= x_idx;
                val_lat <= bcd_val;
                err <= 1'b0;
            end else if (wr_act && below) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = start ? (cmd == CMD_DUMP ? ST_DUMP : ST_BCD) : ST_IDLE;
            ST_BCD:  state_nxt = step == 4'd2 ? ST_FIN : ST_BCD;
            ST_DUMP: state_nxt = step == x_lat ? ST_FIN : ST_DUMP;
            default: state_nxt = ST_IDLE;
        endcase
        step_nxt = (state_nxt == state && state != ST_IDLE) ? step + 4'd1 : 4'd0;
    end

    assign wr_act = state == ST_BCD || state == ST_DUMP;
    assign addr = i_lat + ADDR_W'(step);
    assign below = addr < FONT_END;
    assign digit = step == 4'd0 ? hund : step == 4'd1 ? tens : ones;
    assign mem_we = wr_act && !below;
    assign mem_addr = wr_act ? addr : '0;
    assign mem_wdata = state == ST_BCD ? DATA_W'(digit) : state == ST_DUMP ? reg_data : '0;
    assign reg_idx = state == ST_DUMP ? step : 4'd0;
    assign busy = wr_act;
    assign done = state == ST_FIN;

`ifdef CHIP8_I_INCREMENT_EN
    assign i_update = state == ST_FIN && cmd_lat == CMD_DUMP;
    assign i_new = i_update ? i_lat + ADDR_W'({1'b0, x_lat}) + ADDR_W'(1) : '0;
`else
    assign i_update = 1'b0;
    assign i_new = '0;
`endif
endmodule

// File: tb/tb_chip8_store_unit.sv
// tb_chip8_store_unit: directed vectors for BCD, dump, wrap, busy and mid-op reset
module tb_chip8_store_unit;
    logic clk = 1'b0;
    logic rst, start, cmd;
    logic [11:0] i_reg;
    logic [3:0] x_idx;
    logic [7:0] bcd_val;
    logic [3:0] reg_idx;
    logic [7:0] reg_data;
    logic mem_we;
    logic [11:0] mem_addr;
    logic [7:0] mem_wdata;
    logic busy, done, err, i_update;
    logic [11:0] i_new;
    logic [7:0] rf [16];
    int total = 0;
    int bad = 0;
    int nwr, ndone;

    always #5 clk = ~clk;
    assign reg_data = rf[reg_idx];

    chip8_store_unit dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .i_reg(i_reg),
        .x_idx(x_idx), .bcd_val(bcd_val), .reg_idx(reg_idx), .reg_data(reg_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .i_update(i_update), .i_new(i_new)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic we, input logic [11:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
    endtask

    task automatic go(input logic c, input logic [11:0] i, input logic [3:0] x, input logic [7:0] v);
        start = 1'b1;
        cmd = c;
        i_reg = i;
        x_idx = x;
        bcd_val = v;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cmd = 1'b0;
        i_reg = 12'h0;
        x_idx = 4'd0;
        bcd_val = 8'd0;
        foreach (rf[k]) rf[k] = 8'(k * 3 + 1);
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_iupd", 32'(i_update), 0);
        wr("rst", 1'b0, 12'h000, 8'h00);
        rst = 1'b0;
        tick();

        go(1'b0, 12'h300, 4'd0, 8'd254);
        chk("bcd_busy", 32'(busy), 1);
        wr("bcd0", 1'b1, 12'h300, 8'd2);
        chk("bcd_ridx", 32'(reg_idx), 0);
        tick();
        wr("bcd1", 1'b1, 12'h301, 8'd5);
        tick();
        wr("bcd2", 1'b1, 12'h302, 8'd4);
        tick();
        chk("bcd_done", 32'(done), 1);
        chk("bcd_busy_fin", 32'(busy), 0);
        chk("bcd_iupd", 32'(i_update), 0);
        wr("bcd_fin", 1'b0, 12'h000, 8'h00);
        tick();
        chk("bcd_done_off", 32'(done), 0);

        rf[0] = 8'd11; rf[1] = 8'd22; rf[2] = 8'd33; rf[3] = 8'd44;
        go(1'b1, 12'h400, 4'd3, 8'd0);
        for (int k = 0; k < 4; k++) begin
            wr($sformatf("dump%0d", k), 1'b1, 12'h400 + 12'(k), rf[k]);
            chk($sformatf("dump%0d_ridx", k), 32'(reg_idx), 32'(k));
            tick();
        end
        chk("dump_done", 32'(done), 1);
`ifdef CHIP8_I_INCREMENT_EN
        chk("dump_iupd", 32'(i_update), 1);
        chk("dump_inew", 32'(i_new), 32'h404);
`else
        chk("dump_iupd", 32'(i_update), 0);
        chk("dump_inew", 32'(i_new), 0);
`endif
        chk("dump_err", 32'(err), 0);
        tick();

        go(1'b1, 12'hFFE, 4'd2, 8'd0);
        wr("wrap0", 1'b1, 12'hFFE, rf[0]);
        tick();
        wr("wrap1", 1'b1, 12'hFFF, rf[1]);
        tick();
        chk("wrap2_we", 32'(mem_we), 0);
        chk("wrap2_addr", 32'(mem_addr), 0);
        tick();
        chk("wrap_done", 32'(done), 1);
        chk("wrap_err", 32'(err), 1);
`ifdef CHIP8_I_INCREMENT_EN
        chk("wrap_inew", 32'(i_new), 32'h001);
`endif
        tick();
        chk("err_sticky", 32'(err), 1);

        go(1'b0, 12'h200, 4'd0, 8'd7);
        chk("err_clear", 32'(err), 0);
        nwr = int'(mem_we);
        ndone = int'(done);
        wr("busy0", 1'b1, 12'h200, 8'd0);
        for (int c = 2; c <= 8; c++) begin
            start = (c == 2);
            cmd = 1'b1;
            tick();
            nwr += int'(mem_we);
            ndone += int'(done);
            if (c == 3) wr("busy2", 1'b1, 12'h202, 8'd7);
        end
        start = 1'b0;
        chk("busy_writes", 32'(nwr), 3);
        chk("busy_dones", 32'(ndone), 1);

        go(1'b1, 12'h500, 4'd15, 8'd0);
        tick();
        wr("rst_mid1", 1'b1, 12'h501, rf[1]);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(mem_we), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_addr", 32'(mem_addr), 0);
        tick();
        rst = 1'b0;
        nwr = 0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            nwr += int'(mem_we);
            ndone += int'(done);
        end
        chk("rst_mid_writes", 32'(nwr), 0);
        chk("rst_mid_dones", 32'(ndone), 0);
        chk("rst_mid_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
